pm_modmul_serial: RTL and testbench
===================================

Name: pm_modmul_serial

Overview:
- Digit-serial multiplier over the pseudo-Mersenne field P = 2^K − C_CONST. Default P = 2^255 − 19 (Ed25519).
- Successor to the combinational Karatsuba wrapper. Adds a valid/ready handshake on input and output, a parametrised digit width that trades latency against area, and a generic modulus.
- Sits between the EdDSA point-arithmetic sequencer and the register file. With redux=0 it returns the full 2·BIT_LENGTH product for scalar and hash work.

Parameters:
- BIT_LENGTH, 256, operand width.
- DIGIT_W, 64, bits of B consumed per MUL cycle; must divide BIT_LENGTH. NDIG = BIT_LENGTH/DIGIT_W.
- K, 255, modulus exponent; K ≤ BIT_LENGTH.
- C_CONST, 19, modulus offset; C_CONST < 2^(K/4).
- C_W, 5, width of C_CONST.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- redux  in  1  1 = return A·B mod P; 0 = return raw A·B; sampled at accept
- A  in  BIT_LENGTH  operand A
- B  in  BIT_LENGTH  operand B
- out_valid  out  1  U valid
- out_ready  in  1  consumer accepts U
- U  out  2·BIT_LENGTH  result; upper 2·BIT_LENGTH−K bits are zero when redux=1

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high. rst overrides everything, including mid-operation. Next edge: state=IDLE, in_ready=1, out_valid=0, U=0, digit counter=0, accumulator=0.
- States: IDLE, MUL, FOLD1, FOLD2, FINAL, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture A, B and redux, clear the accumulator, go to MUL. in_ready is 0 in every other state.
- MUL, NDIG cycles, MSB digit first (Horner): acc ← (acc << DIGIT_W) + A·B_digit. acc is 2·BIT_LENGTH bits; it cannot overflow. After the last digit: go to FOLD1 if redux=1, else DONE with U=acc.
- FOLD1: acc ← acc[2·BIT_LENGTH−1:K]·C_CONST + acc[K−1:0]. Multiply by C_CONST uses shift-adds only; no generic multiplier.
- FOLD2: same fold again; the result fits in K+1 bits.
- FINAL: U ← (acc ≥ P) ? acc − P : acc. A single subtraction suffices under the C_CONST bound. Result is canonical in [0, P−1] for any A, B < 2^BIT_LENGTH; non-reduced inputs are legal.
- DONE: out_valid=1 and U held stable until out_ready=1. On that edge: out_valid←0, state←IDLE, U holds its last value. There is no overlap: a new operation is accepted at the earliest on the cycle after the output handshake.
- Latency, with the accept edge counted as edge 0:
  - out_valid rises on edge NDIG+3 for redux=1 (7 at defaults).
  - out_valid rises on edge NDIG for redux=0 (4 at defaults).
  - Latency is independent of operand values.
- Operand changes while not in IDLE are ignored.
- in_valid held high during an operation causes no effect until IDLE.

Optional Feature:
- Macro PM_MODMUL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in any state other than IDLE forces state=IDLE, out_valid=0, in_ready=1 on the next edge. U is unchanged and no result is produced. abort in IDLE is ignored. rst has priority over abort.
- Undefined: no abort port; an operation always runs to completion or until rst.

Test Plan:
- redux=1, A=B=P−1 → U=1 after 7 cycles; out_valid for exactly one cycle with out_ready=1.
- redux=1, A=2, B=2^254 → U=19. Then A=2^256−1, B=1 → U=(2^256−1) mod P = 37.
- redux=0, A=B=2^256−1 → U=2^512−2^257+1, out_valid on edge 4, no fold cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid. U stable, in_ready=0, in_valid pulses ignored. out_ready=1 → IDLE next edge, new op accepted one cycle later.
- Reset mid-MUL (edge 2): next edge in_ready=1, out_valid=0, U=0. A subsequent A=3, B=5, redux=1 gives U=15.
- With PM_MODMUL_ABORT_EN defined: abort during FOLD1 → IDLE next edge, no out_valid. The following A=P, B=7 gives U=0.

Source files
------------

// File: rtl/pm_modmul_serial.sv
// Digit-serial A*B multiplier over the pseudo-Mersenne field P = 2^K - C_CONST, with valid/ready handshakes.
// Define PM_MODMUL_ABORT_EN to add an abort input that cancels an in-flight operation.
module pm_modmul_serial #(
    parameter int BIT_LENGTH = 256,
    parameter int DIGIT_W    = 64,
    parameter int K          = 255,
    parameter int C_CONST    = 19,
    parameter int C_W        = 5
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef PM_MODMUL_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    redux,
    input  logic [BIT_LENGTH-1:0]   A,
    input  logic [BIT_LENGTH-1:0]   B,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*BIT_LENGTH-1:0] U
);

    localparam int NDIG   = BIT_LENGTH / DIGIT_W;
    localparam int ACC_W  = 2 * BIT_LENGTH;
    localparam int PROD_W = BIT_LENGTH + DIGIT_W;
    localparam int CNT_W  = $clog2(NDIG + 1);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NDIG - 1);
    localparam logic [C_W-1:0]   C_BITS     = C_W'(C_CONST);
    localparam logic [ACC_W-1:0] P_MOD      = (ACC_W'(1) << K) - ACC_W'(C_CONST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_FOLD1,
        S_FOLD2,
        S_FINAL,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [BIT_LENGTH-1:0]   r_opA;
    logic [BIT_LENGTH-1:0]   r_opB;
    logic                    r_redux;
    logic [ACC_W-1:0]        r_acc;
    logic [CNT_W-1:0]        r_digitCnt;
    logic [ACC_W-1:0]        r_result;
    logic                    r_outValid;
    logic                    r_inReady;

    logic [DIGIT_W-1:0]      w_digit;
    logic [PROD_W-1:0]       w_partial;
    logic [ACC_W-1:0]        w_mulAcc;
    logic [ACC_W-1:0]        w_fold;
    logic [ACC_W-1:0]        w_final;

    // Since 2^K == C_CONST (mod P), the bits above K are folded back in scaled by C_CONST (shift-adds only).
    function automatic logic [ACC_W-1:0] foldOnce(input logic [ACC_W-1:0] x);
        logic [ACC_W-1:0] hi;
        logic [ACC_W-1:0] sum;
        hi  = ACC_W'(x[ACC_W-1:K]);
        sum = ACC_W'(x[K-1:0]);
        for (int i = 0; i < C_W; i++) begin
            if (C_BITS[i]) begin
                sum = sum + (hi << i);
            end
        end
        return foldOnce_ret(sum);
    endfunction

    function automatic logic [ACC_W-1:0] foldOnce_ret(input logic [ACC_W-1:0] v);
        return v;
    endfunction

    // B is consumed most-significant digit first, so the accumulator follows Horner's rule.
    assign w_digit   = r_opB[BIT_LENGTH-1 -: DIGIT_W];
    assign w_partial = PROD_W'(r_opA) * PROD_W'(w_digit);
    assign w_mulAcc  = (r_acc << DIGIT_W) + ACC_W'(w_partial);
    assign w_fold    = foldOnce(r_acc);
    assign w_final   = (r_acc >= P_MOD) ? (r_acc - P_MOD) : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_digitCnt <= '0;
            r_acc      <= '0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_redux    <= 1'b0;
        end
`ifdef PM_MODMUL_ABORT_EN
        else if (abort && (r_state != S_IDLE)) begin
            r_state    <= S_IDLE;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_digitCnt <= '0;
        end
`endif
        else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_opA      <= A;
                        r_opB      <= B;
                        r_redux    <= redux;
                        r_acc      <= '0;
                        r_digitCnt <= '0;
                        r_inReady  <= 1'b0;
                        r_state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_acc      <= w_mulAcc;
                    r_opB      <= r_opB << DIGIT_W;
                    r_digitCnt <= r_digitCnt + CNT_W'(1);
                    if (r_digitCnt == LAST_DIGIT) begin
                        r_digitCnt <= '0;
                        if (r_redux) begin
                            r_state <= S_FOLD1;
                        end else begin
                            r_result   <= w_mulAcc;
                            r_outValid <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_FOLD1: begin
                    r_acc   <= w_fold;
                    r_state <= S_FOLD2;
                end
                // After the second fold the value is below 2P, so one conditional subtract is canonical.
                S_FOLD2: begin
                    r_acc   <= w_fold;
                    r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_result   <= w_final;
                    r_outValid <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_outValid <= 1'b0;
                    r_inReady  <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign U         = r_result;

endmodule

// File: tb/tb_pm_modmul_serial.sv
// Self-checking bench for pm_modmul_serial: directed field vectors plus randomized operands against a big-integer model.
// Abort scenarios are compiled in when PM_MODMUL_ABORT_EN is defined.
module tb_pm_modmul_serial;

    localparam int BL = 256;
    localparam int DW = 64;
    localparam int KX = 255;
    localparam int CC = 19;
    localparam int CW = 5;
    localparam logic [511:0] PMOD = (512'd1 << 255) - 512'd19;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         redux;
    logic [255:0] A;
    logic [255:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] U;
`ifdef PM_MODMUL_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;

    pm_modmul_serial #(
        .BIT_LENGTH(BL),
        .DIGIT_W   (DW),
        .K         (KX),
        .C_CONST   (CC),
        .C_W       (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef PM_MODMUL_ABORT_EN
        .abort    (abort),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .redux    (redux),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .U        (U)
    );

    always #5 clk = ~clk;

    // Reference: exact product, optionally reduced with the arithmetic modulo operator.
    function automatic logic [511:0] refModel(input logic [255:0] a, input logic [255:0] b, input logic r);
        logic [511:0] prod;
        prod = {256'd0, a} * {256'd0, b};
        return r ? (prod % PMOD) : prod;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] pickOperand();
        logic [255:0] v;
        case ($urandom_range(0, 3))
            0:       v = '1;
            1:       v = 256'(PMOD) + 256'($urandom_range(0, 40)) - 256'd20;
            default: v = rand256();
        endcase
        return v;
    endfunction

    // Drives one accept edge (edge 0), then scrambles the operands to prove they are not re-sampled.
    task automatic applyStimulus(input logic [255:0] a, input logic [255:0] b, input logic r);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        redux    = r;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = rand256();
        B        = rand256();
        redux    = ~r;
    endtask

    task automatic collectResult(output int lat, output logic [511:0] res);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        if (out_valid !== 1'b1) lat = -1;
        res = U;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        redux     = 1'b0;
        A         = '0;
        B         = '0;
`ifdef PM_MODMUL_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (U !== 512'd0) begin errors++; $display("[TB] FAIL reset_U: got %h expected 0", U); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_field_vectors();
        logic [255:0] va [3];
        logic [255:0] vb [3];
        logic [511:0] ve [3];
        logic [511:0] res;
        int lat;
        va[0] = 256'(PMOD - 512'd1); vb[0] = 256'(PMOD - 512'd1); ve[0] = 512'd1;
        va[1] = 256'd2;              vb[1] = 256'd1 << 254;       ve[1] = 512'd19;
        va[2] = '1;                  vb[2] = 256'd1;              ve[2] = 512'd37;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(va[i], vb[i], 1'b1);
            collectResult(lat, res);
            checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL field_latency[%0d]: got %0d expected 7", i, lat); end
            checks++; if (res !== ve[i]) begin errors++; $display("[TB] FAIL field_U[%0d]: got %h expected %h", i, res, ve[i]); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL field_single_pulse[%0d]: got out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_raw_product();
        logic [511:0] exp;
        logic [511:0] res;
        int lat;
        exp = 512'd1 - (512'd1 << 257);
        out_ready = 1'b1;
        applyStimulus('1, '1, 1'b0);
        collectResult(lat, res);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL raw_latency: got %0d expected 4", lat); end
        checks++; if (res !== exp) begin errors++; $display("[TB] FAIL raw_U: got %h expected %h", res, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] exp;
        logic [511:0] res;
        int lat;
        a = rand256();
        b = rand256();
        exp = refModel(a, b, 1'b1);
        out_ready = 1'b0;
        applyStimulus(a, b, 1'b1);
        collectResult(lat, res);
        checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL bp_latency: got %0d expected 7", lat); end
        checks++; if (res !== exp) begin errors++; $display("[TB] FAIL bp_U: got %h expected %h", res, exp); end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            A = rand256();
            B = rand256();
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL bp_hold_flags[%0d]: got out_valid=%b in_ready=%b expected 1/0", c, out_valid, in_ready);
            end
            checks++; if (U !== exp) begin errors++; $display("[TB] FAIL bp_hold_U[%0d]: got %h expected %h", c, U, exp); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        checks++; if (U !== exp) begin errors++; $display("[TB] FAIL bp_U_after: got %h expected %h", U, exp); end
        a = rand256();
        b = rand256();
        exp = refModel(a, b, 1'b0);
        applyStimulus(a, b, 1'b0);
        collectResult(lat, res);
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL bp_next_latency: got %0d expected 4", lat); end
        checks++; if (res !== exp) begin errors++; $display("[TB] FAIL bp_next_U: got %h expected %h", res, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        logic [511:0] res;
        int lat;
        out_ready = 1'b1;
        applyStimulus(rand256(), rand256(), 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_flags: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++; if (U !== 512'd0) begin errors++; $display("[TB] FAIL midrst_U: got %h expected 0", U); end
        applyStimulus(256'd3, 256'd5, 1'b1);
        collectResult(lat, res);
        checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 7", lat); end
        checks++; if (res !== 512'd15) begin errors++; $display("[TB] FAIL midrst_U_after: got %h expected %h", res, 512'd15); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [255:0] a;
        logic [255:0] b;
        logic         r;
        logic [511:0] exp;
        logic [511:0] res;
        int lat;
        int expLat;
        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            a = pickOperand();
            b = pickOperand();
            r = 1'($urandom_range(0, 1));
            exp = refModel(a, b, r);
            expLat = r ? 7 : 4;
            applyStimulus(a, b, r);
            collectResult(lat, res);
            checks++; if (lat !== expLat) begin errors++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, expLat); end
            checks++; if (res !== exp) begin errors++; $display("[TB] FAIL rand_U[%0d]: got %h expected %h", n, res, exp); end
            @(posedge clk); #1;
        end
    endtask

`ifdef PM_MODMUL_ABORT_EN
    task automatic test_abort();
        logic [511:0] prevU;
        logic [511:0] res;
        int lat;
        int seenValid;
        out_ready = 1'b1;
        prevU = U;
        applyStimulus(rand256(), rand256(), 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_flags: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        checks++; if (U !== prevU) begin errors++; $display("[TB] FAIL abort_U: got %h expected %h", U, prevU); end
        seenValid = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seenValid++;
        end
        checks++; if (seenValid !== 0) begin errors++; $display("[TB] FAIL abort_no_result: got %0d valid cycles expected 0", seenValid); end
        applyStimulus(256'(PMOD), 256'd7, 1'b1);
        collectResult(lat, res);
        checks++; if (lat !== 7) begin errors++; $display("[TB] FAIL abort_next_latency: got %0d expected 7", lat); end
        checks++; if (res !== 512'd0) begin errors++; $display("[TB] FAIL abort_next_U: got %h expected 0", res); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_field_vectors();
        test_raw_product();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
`ifdef PM_MODMUL_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
